pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 74 +++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencer with stall hold, pending redirect and branch/jump/eret/exception steering.
// Exception support (exc_req, eret, epc) is compiled in only when PC_SEQ_EXC_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        pend,
  output logic        misalign
);
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, PEND = 2'd2} state_t;
  state_t      state_q;
  logic [31:0] pc_q, pend_q, tgt;
  logic        misalign_q, exc, er, redir;
`ifdef PC_SEQ_EXC_EN
  assign exc = exc_req;
  assign er  = eret;
`else
  logic unused_exc;
  assign exc = 1'b0;
  assign er  = 1'b0;
  assign unused_exc = exc_req ^ eret;
`endif
  assign redir    = er | jmp_valid | br_taken;
  assign tgt      = er ? epc : jmp_valid ? jmp_target : br_target;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign pend     = state_q == PEND;
  assign misalign = misalign_q;
  assign if_valid = (state_q == RUN) & ~stall & ~reset;
  // A HOLD exit re-presents the same pc so the stalled fetch is consumed once.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      misalign_q <= 1'b0;
      state_q    <= RUN;
    end else if (exc) begin
      pc_q       <= {EXC_VEC[31:2], 2'b00};
      pend_q     <= '0;
      misalign_q <= |EXC_VEC[1:0];
      state_q    <= RUN;
    end else if (stall) begin
      misalign_q <= 1'b0;
      if (redir) begin
        pend_q  <= tgt;
        state_q <= PEND;
      end else if (state_q != PEND) state_q <= HOLD;
    end else begin
      state_q <= RUN;
      if (redir) begin
        pc_q       <= {tgt[31:2], 2'b00};
        misalign_q <= |tgt[1:0];
      end else if (state_q == PEND) begin
        pc_q       <= {pend_q[31:2], 2'b00};
        misalign_q <= |pend_q[1:0];
      end else begin
        pc_q       <= state_q == RUN ? pc_plus4 : pc_q;
        misalign_q <= 1'b0;
      end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural fetch model.
module tb_pc_sequencer;
  localparam logic [31:0] RST = 32'h0000_3000;
  localparam logic [31:0] VEC = 32'h0000_4180;
`ifdef PC_SEQ_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b0, stall, br_taken, jmp_valid, exc_req, eret;
  logic [31:0] br_target, jmp_target, epc, pc, pc_plus4;
  logic        if_valid, pend, misalign;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_pc, m_ptgt;
  logic        m_has_pend, m_held, m_mis;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc), .pc_plus4(pc_plus4), .if_valid(if_valid), .pend(pend), .misalign(misalign)
  );

  task automatic idle();
    stall = 0; br_taken = 0; jmp_valid = 0; exc_req = 0; eret = 0;
    br_target = 0; jmp_target = 0; epc = 0;
  endtask

  task automatic model_reset();
    m_pc = RST; m_ptgt = 0; m_has_pend = 0; m_held = 0; m_mis = 0;
  endtask

  // Advance one clock; the model applies the fetch rules to the inputs held over this cycle.
  task automatic tick();
    logic        ex, er, r;
    logic [31:0] t;
    ex = EXC_EN && exc_req;
    er = EXC_EN && eret;
    r  = er || jmp_valid || br_taken;
    t  = er ? epc : (jmp_valid ? jmp_target : br_target);
    if (ex) begin
      m_pc = VEC & ~32'd3; m_mis = VEC[1:0] != 0; m_has_pend = 0; m_held = 0;
    end else if (stall) begin
      m_mis = 0; m_held = 1;
      if (r) begin m_has_pend = 1; m_ptgt = t; end
    end else if (r) begin
      m_pc = t & ~32'd3; m_mis = t[1:0] != 0; m_has_pend = 0; m_held = 0;
    end else if (m_has_pend) begin
      m_pc = m_ptgt & ~32'd3; m_mis = m_ptgt[1:0] != 0; m_has_pend = 0; m_held = 0;
    end else if (m_held) begin
      m_held = 0; m_mis = 0;
    end else begin
      m_pc = m_pc + 32'd4; m_mis = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    reset = 1;
    #1;
    model_reset();
    n_cmp++; if (pc !== RST) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RST); end
    n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL reset_pend: got %b want 0", pend); end
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_ifvalid: got %b want 0", if_valid); end
    @(negedge clk);
    reset = 0;
    #1;
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL release_ifvalid: got %b want 1", if_valid); end
  endtask

  task automatic test_seq();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pc !== RST + 32'(4 * i)) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, RST + 32'(4 * i)); end
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL seq_ifvalid%0d: got %b want 1", i, if_valid); end
      n_cmp++; if (pc_plus4 !== m_pc + 32'd4) begin n_err++; $display("FAIL seq_plus4%0d: got %h want %h", i, pc_plus4, m_pc + 32'd4); end
      tick();
    end
  endtask

  task automatic test_pend();
    tick();
    n_cmp++; if (pc !== 32'h3010) begin n_err++; $display("FAIL pend_start: got %h want 00003010", pc); end
    stall = 1; br_taken = 1; br_target = 32'h3100;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL pend_ifvalid: got %b want 0", if_valid); end
    tick();
    br_taken = 0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (pc !== 32'h3010) begin n_err++; $display("FAIL pend_hold%0d: got %h want 00003010", i, pc); end
      n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL pend_flag%0d: got %b want 1", i, pend); end
      if (i == 1) stall = 0;
      tick();
    end
    n_cmp++; if (pc !== 32'h3100) begin n_err++; $display("FAIL pend_load: got %h want 00003100", pc); end
    n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL pend_clear: got %b want 0", pend); end
  endtask

  task automatic test_priority();
    idle();
    jmp_valid = 1; jmp_target = 32'h3200; br_taken = 1; br_target = 32'h3300;
    tick();
    n_cmp++; if (pc !== 32'h3200) begin n_err++; $display("FAIL prio_jmp: got %h want 00003200", pc); end
    idle();
  endtask

  task automatic test_exc();
    logic [31:0] held;
    held = m_pc;
    stall = 1; br_taken = 1; br_target = 32'h3500;
    tick();
    n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL exc_setup_pend: got %b want 1", pend); end
    br_taken = 0; exc_req = 1;
    tick();
    n_cmp++; if (pc !== (EXC_EN ? VEC : held)) begin n_err++; $display("FAIL exc_pc: got %h want %h", pc, EXC_EN ? VEC : held); end
    n_cmp++; if (pend !== !EXC_EN) begin n_err++; $display("FAIL exc_pend: got %b want %b", pend, !EXC_EN); end
    idle();
    tick();
    n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL exc_after: got %h want %h", pc, m_pc); end
  endtask

  task automatic test_misalign_wrap();
    idle();
    br_taken = 1; br_target = 32'h3006;
    tick();
    n_cmp++; if (pc !== 32'h3004) begin n_err++; $display("FAIL mis_pc: got %h want 00003004", pc); end
    n_cmp++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", misalign); end
    idle();
    tick();
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_drop: got %b want 0", misalign); end
    n_cmp++; if (pc !== 32'h3008) begin n_err++; $display("FAIL mis_next: got %h want 00003008", pc); end
    jmp_valid = 1; jmp_target = 32'hFFFF_FFFC;
    tick();
    idle();
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4); end
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
  endtask

  task automatic test_async_reset();
    idle();
    stall = 1; br_taken = 1; br_target = 32'h3700;
    tick();
    n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL ares_setup: got %b want 1", pend); end
    @(posedge clk);
    #2 reset = 1;
    #1;
    model_reset();
    n_cmp++; if (pc !== RST) begin n_err++; $display("FAIL ares_pc: got %h want %h", pc, RST); end
    n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL ares_pend: got %b want 0", pend); end
    @(negedge clk);
    idle();
    reset = 0;
    #1;
    n_cmp++; if (pc !== RST || if_valid !== 1'b1) begin n_err++; $display("FAIL ares_first: got pc %h v %b want %h v 1", pc, if_valid, RST); end
    tick();
    n_cmp++; if (pc !== RST + 32'd4) begin n_err++; $display("FAIL ares_second: got %h want %h", pc, RST + 32'd4); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall      = $urandom_range(2) == 0;
      br_taken   = $urandom_range(3) == 0;
      jmp_valid  = $urandom_range(5) == 0;
      exc_req    = $urandom_range(15) == 0;
      eret       = $urandom_range(9) == 0;
      br_target  = $urandom;
      jmp_target = $urandom;
      epc        = $urandom;
      if ($urandom_range(1) == 0) begin br_target[1:0] = 0; jmp_target[1:0] = 0; epc[1:0] = 0; end
      #1;
      n_cmp++; if (if_valid !== (!m_held && !stall)) begin n_err++; $display("FAIL rnd_ifvalid@%0d: got %b want %b", i, if_valid, !m_held && !stall); end
      tick();
      n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc@%0d: got %h want %h", i, pc, m_pc); end
      n_cmp++; if (pend !== m_has_pend) begin n_err++; $display("FAIL rnd_pend@%0d: got %b want %b", i, pend, m_has_pend); end
      n_cmp++; if (misalign !== m_mis) begin n_err++; $display("FAIL rnd_mis@%0d: got %b want %b", i, misalign, m_mis); end
      n_cmp++; if (pc_plus4 !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_plus4@%0d: got %h want %h", i, pc_plus4, m_pc + 32'd4); end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_seq();
    test_pend();
    test_priority();
    test_exc();
    test_misalign_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
